// File: rtl/beta_decode_if.sv
// Fetch -> decode -> execute handshake bundle for the Beta decode stage.
// The fetch/execute side uses the master modport, the decode stage the slave.
interface beta_decode_if #(
    parameter int ALU_FN_W = 6
);
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_instr;
    logic [31:0]         in_pc;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_pc;
    logic [ALU_FN_W-1:0] out_alu_fn;
    logic [4:0]          out_rc;
    logic [4:0]          out_ra;
    logic [4:0]          out_rb;
    logic [31:0]         out_lit;
    logic                out_use_lit;
    logic                out_wr_en;
    logic                out_mem_rd;
    logic                out_mem_wr;
    logic                out_ldr;
    logic [1:0]          out_branch;
    logic [1:0]          out_md_op;
    logic                out_illegal;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_alu_fn, out_rc, out_ra, out_rb,
               out_lit, out_use_lit, out_wr_en, out_mem_rd, out_mem_wr, out_ldr,
               out_branch, out_md_op, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_alu_fn, out_rc, out_ra, out_rb,
               out_lit, out_use_lit, out_wr_en, out_mem_rd, out_mem_wr, out_ldr,
               out_branch, out_md_op, out_illegal
    );
endinterface

// File: rtl/beta_decode.sv
// Beta instruction decode stage with a two-entry (main + skid) output buffer.
// Optional feature macro: BETA_MULDIV_EN enables MUL/DIV decode (md_op);
// without it those opcodes are illegal and md_op stays 00.
//
// state    | meaning
// ST_EMPTY | no decoded entry held, out_valid = 0
// ST_ONE   | main holds an entry, skid empty, in_ready = 1
// ST_TWO   | main and skid both hold entries, in_ready = 0
module beta_decode #(
    parameter int ALU_FN_W = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    beta_decode_if.slave  bus
);
    localparam logic [5:0] FN_ADD   = 6'b010000;
    localparam logic [5:0] FN_SUB   = 6'b010001;
    localparam logic [5:0] FN_CMPEQ = 6'b000001;
    localparam logic [5:0] FN_CMPLT = 6'b000010;
    localparam logic [5:0] FN_CMPLE = 6'b000011;
    localparam logic [5:0] FN_AND   = 6'b101000;
    localparam logic [5:0] FN_OR    = 6'b101110;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_XNOR  = 6'b101001;
    localparam logic [5:0] FN_SHL   = 6'b110000;
    localparam logic [5:0] FN_SHR   = 6'b110001;
    localparam logic [5:0] FN_SRA   = 6'b110011;

    typedef struct packed {
        logic [31:0]         pc;
        logic [ALU_FN_W-1:0] alu_fn;
        logic [4:0]          rc;
        logic [4:0]          ra;
        logic [4:0]          rb;
        logic [31:0]         lit;
        logic                use_lit;
        logic                wr_en;
        logic                mem_rd;
        logic                mem_wr;
        logic                ldr;
        logic [1:0]          branch;
        logic [1:0]          md_op;
        logic                illegal;
    } ctrl_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // Opcode -> control word. Rc = 31 is the zero register, so writes to it
    // are suppressed for every writing instruction.
    function automatic ctrl_t decode(input logic [31:0] instr, input logic [31:0] pc);
        ctrl_t      c;
        logic [5:0] op;
        logic       rc_live;
        op      = instr[31:26];
        rc_live = (instr[25:21] != 5'd31);
        c         = '0;
        c.pc      = pc;
        c.alu_fn  = FN_ADD;
        c.rc      = instr[25:21];
        c.ra      = instr[20:16];
        c.rb      = instr[15:11];
        c.lit     = {{16{instr[15]}}, instr[15:0]};
        if (op[5]) begin
            // 0x20-0x2F register forms, 0x30-0x3F literal forms of the same op
            c.use_lit = op[4];
            c.wr_en   = rc_live;
            case (op[3:0])
                4'h0: c.alu_fn = FN_ADD;
                4'h1: c.alu_fn = FN_SUB;
`ifdef BETA_MULDIV_EN
                4'h2: c.md_op  = 2'b01;
                4'h3: c.md_op  = 2'b10;
`endif
                4'h4: c.alu_fn = FN_CMPEQ;
                4'h5: c.alu_fn = FN_CMPLT;
                4'h6: c.alu_fn = FN_CMPLE;
                4'h8: c.alu_fn = FN_AND;
                4'h9: c.alu_fn = FN_OR;
                4'hA: c.alu_fn = FN_XOR;
                4'hB: c.alu_fn = FN_XNOR;
                4'hC: c.alu_fn = FN_SHL;
                4'hD: c.alu_fn = FN_SHR;
                4'hE: c.alu_fn = FN_SRA;
                default: begin
                    c.illegal = 1'b1;
                    c.use_lit = 1'b0;
                    c.wr_en   = 1'b0;
                end
            endcase
        end else begin
            case (op)
                6'h18: begin
                    c.use_lit = 1'b1;
                    c.mem_rd  = 1'b1;
                    c.wr_en   = rc_live;
                end
                6'h19: begin
                    // store data register travels on the rb specifier
                    c.use_lit = 1'b1;
                    c.mem_wr  = 1'b1;
                    c.rb      = instr[25:21];
                end
                6'h1B: begin
                    c.branch = 2'b11;
                    c.wr_en  = rc_live;
                end
                6'h1C: begin
                    c.branch = 2'b01;
                    c.wr_en  = rc_live;
                end
                6'h1D: begin
                    c.branch = 2'b10;
                    c.wr_en  = rc_live;
                end
                6'h1F: begin
                    c.ldr     = 1'b1;
                    c.mem_rd  = 1'b1;
                    c.use_lit = 1'b1;
                    c.wr_en   = rc_live;
                end
                default: c.illegal = 1'b1;
            endcase
        end
        return c;
    endfunction

    state_t state_q, state_d;
    ctrl_t  main_q, main_d;
    ctrl_t  skid_q, skid_d;
    ctrl_t  dec;
    logic   accept;
    logic   drain;

    // in_ready comes straight from the state flop, so out_ready never
    // reaches fetch combinationally.
    assign bus.in_ready = (state_q != ST_TWO);
    assign accept       = bus.in_valid & bus.in_ready;
    assign drain        = (state_q != ST_EMPTY) & bus.out_ready;
    assign dec          = decode(bus.in_instr, bus.in_pc);

    // Buffer state register and data registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Next-state: flush wins, then refill main from skid or input, else park in skid.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (bus.flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_d  = dec;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    case ({accept, drain})
                        2'b10: begin
                            skid_d  = dec;
                            state_d = ST_TWO;
                        end
                        2'b11: main_d  = dec;
                        2'b01: state_d = ST_EMPTY;
                        default: ;
                    endcase
                end
                ST_TWO: begin
                    if (drain) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    assign bus.out_valid   = (state_q != ST_EMPTY);
    assign bus.out_pc      = main_q.pc;
    assign bus.out_alu_fn  = main_q.alu_fn;
    assign bus.out_rc      = main_q.rc;
    assign bus.out_ra      = main_q.ra;
    assign bus.out_rb      = main_q.rb;
    assign bus.out_lit     = main_q.lit;
    assign bus.out_use_lit = main_q.use_lit;
    assign bus.out_wr_en   = main_q.wr_en;
    assign bus.out_mem_rd  = main_q.mem_rd;
    assign bus.out_mem_wr  = main_q.mem_wr;
    assign bus.out_ldr     = main_q.ldr;
    assign bus.out_branch  = main_q.branch;
    assign bus.out_md_op   = main_q.md_op;
    assign bus.out_illegal = main_q.illegal;
endmodule

// File: tb/tb_beta_decode.sv
// Bench for beta_decode: directed literal checks plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_beta_decode;
    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  alu;
        logic [4:0]  rc;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] lit;
        logic        use_lit;
        logic        wr_en;
        logic        mem_rd;
        logic        mem_wr;
        logic        ldr;
        logic [1:0]  branch;
        logic [1:0]  md_op;
        logic        illegal;
    } exp_t;

    localparam int NARITH = 12;
    localparam logic [5:0] ARITH_OP [NARITH] = '{
        6'h20, 6'h21, 6'h24, 6'h25, 6'h26, 6'h28,
        6'h29, 6'h2A, 6'h2B, 6'h2C, 6'h2D, 6'h2E};
    localparam logic [5:0] ARITH_FN [NARITH] = '{
        6'b010000, 6'b010001, 6'b000001, 6'b000010, 6'b000011, 6'b101000,
        6'b101110, 6'b100110, 6'b101001, 6'b110000, 6'b110001, 6'b110011};

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    beta_decode_if bif ();
    beta_decode dut (.clk(clk), .rst_n(rst_n), .bus(bif));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference decode: table lookup for ALU ops, explicit list for the rest.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        int   op;
        int   rcf;
        int   s;
        bit   writes;
        op  = int'(ins[31:26]);
        rcf = int'(ins[25:21]);
        s   = int'(ins[15:0]);
        if (s >= 32768) s = s - 65536;
        e         = '0;
        e.pc      = pc;
        e.alu     = 6'b010000;
        e.rc      = ins[25:21];
        e.ra      = ins[20:16];
        e.rb      = ins[15:11];
        e.lit     = 32'(s);
        e.illegal = 1'b1;
        writes    = 1'b0;
        for (int k = 0; k < NARITH; k++) begin
            if (op == int'(ARITH_OP[k]) || op == int'(ARITH_OP[k]) + 16) begin
                e.illegal = 1'b0;
                e.alu     = ARITH_FN[k];
                e.use_lit = (op >= 48);
                writes    = 1'b1;
            end
        end
`ifdef BETA_MULDIV_EN
        if (op == 34 || op == 50 || op == 35 || op == 51) begin
            e.illegal = 1'b0;
            e.md_op   = (op == 34 || op == 50) ? 2'b01 : 2'b10;
            e.use_lit = (op >= 48);
            writes    = 1'b1;
        end
`endif
        case (op)
            24: begin e.illegal = 0; e.use_lit = 1; e.mem_rd = 1; writes = 1; end
            25: begin e.illegal = 0; e.use_lit = 1; e.mem_wr = 1; e.rb = ins[25:21]; end
            27: begin e.illegal = 0; e.branch = 2'b11; writes = 1; end
            28: begin e.illegal = 0; e.branch = 2'b01; writes = 1; end
            29: begin e.illegal = 0; e.branch = 2'b10; writes = 1; end
            31: begin e.illegal = 0; e.ldr = 1; e.mem_rd = 1; e.use_lit = 1; writes = 1; end
            default: ;
        endcase
        e.wr_en = writes && (rcf != 31);
        return e;
    endfunction

    exp_t mq[$];
    bit   zero_data;
    bit   model_live;

    initial begin
        zero_data  = 1'b0;
        model_live = 1'b0;
    end

    // Reference buffer: a FIFO of at most two decoded entries.
    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            zero_data  = 1'b1;
            model_live = 1'b1;
        end else if (model_live) begin
            if (bif.flush) begin
                mq.delete();
            end else begin
                bit acc;
                acc = bif.in_valid && (mq.size() < 2);
                if (bif.out_ready && mq.size() > 0) void'(mq.pop_front());
                if (acc) begin
                    mq.push_back(ref_decode(bif.in_instr, bif.in_pc));
                    zero_data = 1'b0;
                end
            end
        end
    end

    exp_t got;
    always_comb begin
        got = '{pc: bif.out_pc, alu: bif.out_alu_fn, rc: bif.out_rc, ra: bif.out_ra,
                rb: bif.out_rb, lit: bif.out_lit, use_lit: bif.out_use_lit,
                wr_en: bif.out_wr_en, mem_rd: bif.out_mem_rd, mem_wr: bif.out_mem_wr,
                ldr: bif.out_ldr, branch: bif.out_branch, md_op: bif.out_md_op,
                illegal: bif.out_illegal};
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_live) begin
            chk("out_valid", 128'(bif.out_valid), 128'(mq.size() > 0));
            chk("in_ready", 128'(bif.in_ready), 128'(mq.size() < 2));
            if (mq.size() > 0) chk("entry", 128'(got), 128'(mq[0]));
            else if (zero_data) chk("reset_data", 128'(got), 128'(0));
        end
    end

    task automatic cyc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        bif.in_valid = v;
        bif.in_instr = ins;
        bif.in_pc    = pc;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] op;
        logic [4:0] rc;
        logic [31:0] w;
        op = 6'($urandom_range(0, 63));
        rc = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
        w  = $urandom;
        return {op, rc, w[20:0]};
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bif.flush = 1'b0;
        bif.out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);

        cyc();
        cyc();
        chk("rst_out_valid", 128'(bif.out_valid), 128'(0));
        chk("rst_in_ready", 128'(bif.in_ready), 128'(1));
        chk("rst_pc", 128'(bif.out_pc), 128'(0));
        chk("rst_lit", 128'(bif.out_lit), 128'(0));
        rst_n = 1'b1;
        cyc();

        // ADD R2,R3,R1
        bif.out_ready = 1'b1;
        drive(1'b1, 32'h80430800, 32'h104);
        cyc();
        chk("add_valid", 128'(bif.out_valid), 128'(1));
        chk("add_fn", 128'(bif.out_alu_fn), 128'(6'b010000));
        chk("add_rc", 128'(bif.out_rc), 128'(2));
        chk("add_ra", 128'(bif.out_ra), 128'(3));
        chk("add_rb", 128'(bif.out_rb), 128'(1));
        chk("add_use_lit", 128'(bif.out_use_lit), 128'(0));
        chk("add_wr_en", 128'(bif.out_wr_en), 128'(1));

        // ADDC into R31: literal form, write suppressed
        drive(1'b1, 32'hC3E2FFFF, 32'h108);
        cyc();
        chk("addc_lit", 128'(bif.out_lit), 128'(32'hFFFFFFFF));
        chk("addc_use_lit", 128'(bif.out_use_lit), 128'(1));
        chk("addc_wr_en", 128'(bif.out_wr_en), 128'(0));
        chk("addc_pc", 128'(bif.out_pc), 128'(32'h108));
        drive(1'b0, 32'h0, 32'h0);
        cyc();

        // ST
        drive(1'b1, 32'h64A30008, 32'h10C);
        cyc();
        chk("st_mem_wr", 128'(bif.out_mem_wr), 128'(1));
        chk("st_rb", 128'(bif.out_rb), 128'(5));
        chk("st_wr_en", 128'(bif.out_wr_en), 128'(0));
        chk("st_lit", 128'(bif.out_lit), 128'(8));
        drive(1'b0, 32'h0, 32'h0);
        cyc();

        // MUL R4 <- R1 * R2
        drive(1'b1, {6'h22, 5'd4, 5'd1, 5'd2, 11'd0}, 32'h110);
        cyc();
`ifdef BETA_MULDIV_EN
        chk("mul_md_op", 128'(bif.out_md_op), 128'(1));
        chk("mul_illegal", 128'(bif.out_illegal), 128'(0));
        chk("mul_wr_en", 128'(bif.out_wr_en), 128'(1));
`else
        chk("mul_md_op", 128'(bif.out_md_op), 128'(0));
        chk("mul_illegal", 128'(bif.out_illegal), 128'(1));
        chk("mul_wr_en", 128'(bif.out_wr_en), 128'(0));
`endif
        drive(1'b0, 32'h0, 32'h0);
        cyc();

        // back-pressure: four offers with out_ready low, only two land
        bif.out_ready = 1'b0;
        drive(1'b1, 32'h80430800, 32'h200);
        cyc();
        chk("bp1_in_ready", 128'(bif.in_ready), 128'(1));
        chk("bp1_pc", 128'(bif.out_pc), 128'(32'h200));
        drive(1'b1, 32'h80430800, 32'h204);
        cyc();
        chk("bp2_in_ready", 128'(bif.in_ready), 128'(0));
        drive(1'b1, 32'h80430800, 32'h208);
        cyc();
        chk("bp3_in_ready", 128'(bif.in_ready), 128'(0));
        drive(1'b1, 32'h80430800, 32'h20C);
        cyc();
        chk("bp4_pc_held", 128'(bif.out_pc), 128'(32'h200));
        drive(1'b0, 32'h0, 32'h0);
        bif.out_ready = 1'b1;
        cyc();
        chk("bp_drain_pc", 128'(bif.out_pc), 128'(32'h204));
        chk("bp_drain_in_ready", 128'(bif.in_ready), 128'(1));
        cyc();
        chk("bp_empty", 128'(bif.out_valid), 128'(0));

        // flush with both entries full and an input offered
        bif.out_ready = 1'b0;
        drive(1'b1, 32'h80430800, 32'h300);
        cyc();
        drive(1'b1, 32'h80430800, 32'h304);
        cyc();
        chk("fl_full", 128'(bif.in_ready), 128'(0));
        bif.flush = 1'b1;
        drive(1'b1, 32'h80430800, 32'h308);
        cyc();
        chk("fl_out_valid", 128'(bif.out_valid), 128'(0));
        chk("fl_in_ready", 128'(bif.in_ready), 128'(1));
        bif.flush = 1'b0;
        bif.out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        cyc();
        chk("fl_dropped", 128'(bif.out_valid), 128'(0));

        // randomized traffic with three back-pressure levels
        for (int ph = 0; ph < 3; ph++) begin
            for (int n = 0; n < 1500; n++) begin
                rst_n         = ($urandom_range(0, 299) != 0);
                bif.flush     = ($urandom_range(0, 49) == 0);
                bif.out_ready = ($urandom_range(0, 9) < (ph == 0 ? 10 : (ph == 1 ? 6 : 2)));
                drive($urandom_range(0, 9) < 7, rand_instr(), $urandom);
                cyc();
            end
        end

        rst_n = 1'b1;
        bif.flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
